// File: rtl/mux_arb_rr_pkg.sv
// Shared types for the arbitrated registered multiplexer.
package mux_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_t;
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

endpackage

// File: rtl/mux_arb_rr_grant.sv
// Combinational arbiter: fixed lowest-index or rotating search starting at ptr.
module rr_grant
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  mode_t           mode,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int   start;
    int   c;
    logic found;

    assign any = |req;

    // Walk channels in priority order; the wrap is explicit so non-power-of-2 N works.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        start = (mode == MODE_RR) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            c = start + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDXW'(c);
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-input registered mux with valid/ready on every port and fixed/round-robin
// arbitration; the output register holds its word under backpressure.
module mux_arb_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int N     = 4,
    localparam int IDXW  = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [N-1:0][WIDTH-1:0]  in_data,
    input  logic [N-1:0]             in_valid,
    output logic [N-1:0]             in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDXW-1:0]          out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    state_t          state, state_nxt;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_nxt;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] idx;
    logic            any;
    logic            load_ok;
    logic            load;
    mode_t           mode_q;

    assign mode_q    = mode_t'(mode);
    assign out_valid = (state == ST_FULL);
    assign load_ok   = !out_valid || out_ready;
    assign load      = load_ok && any;
    assign in_ready  = (rst_n && load_ok) ? grant : '0;
    assign ptr_nxt   = (idx == IDXW'(N - 1)) ? '0 : idx + 1'b1;

    rr_grant #(.N(N)) u_grant (
        .req   (in_valid),
        .ptr   (ptr),
        .mode  (mode_q),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (any) state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !any) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= in_data[idx];
                out_sel  <= idx;
                // Only round-robin grants move the pointer; fixed mode leaves it parked.
                if (mode_q == MODE_RR) ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Scoreboard bench for mux_arb_rr: reference arbiter predicts grants, a monitor
// pops expected words on every output handshake.
module tb_mux_arb_rr;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                mode;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [W-1:0]        out_data;
    logic [IW-1:0]       out_sel;
    logic                out_valid;
    logic                out_ready;

    // Second instance with N=3 for the pointer wrap case.
    logic                b_rst_n;
    logic                b_mode;
    logic [2:0][W-1:0]   b_in_data;
    logic [2:0]          b_in_valid;
    logic [2:0]          b_in_ready;
    logic [W-1:0]        b_out_data;
    logic [1:0]          b_out_sel;
    logic                b_out_valid;
    logic                b_out_ready;

    mux_arb_rr #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_arb_rr #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst_n(b_rst_n), .mode(b_mode), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] sel;
        logic [W-1:0]  data;
    } word_t;

    word_t q[$];
    int    tests = 0;
    int    fails = 0;
    bit    m_full = 1'b0;
    int    m_ptr = 0;
    int    lastg = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: first requesting channel in the rotated search order.
    function automatic int pick(input logic [N-1:0] v, input bit rr, input int p);
        int start;
        start = rr ? p : 0;
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    // One cycle: inputs already driven; check at negedge, advance model, return after edge.
    task automatic step();
        int    g;
        word_t w;
        @(negedge clk);
        if (!rst_n) begin
            chk("in_ready_rst", in_ready, 0);
            m_full = 1'b0;
            m_ptr  = 0;
            lastg  = -1;
            q.delete();
        end else begin
            chk("out_valid", out_valid, m_full);
            g = (!m_full || out_ready) ? pick(in_valid, mode, m_ptr) : -1;
            chk("in_ready", in_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
            lastg = g;
            if (g >= 0) begin
                w.sel  = IW'(g);
                w.data = in_data[g];
                q.push_back(w);
                if (mode) m_ptr = (g + 1) % N;
                m_full = 1'b1;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake consumes the oldest predicted word.
    always @(negedge clk) begin
        word_t w;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_extra: got sel %0d data %0h expected no word", out_sel, out_data);
            end else begin
                w = q.pop_front();
                chk("out_sel", out_sel, w.sel);
                chk("out_data", out_data, w.data);
            end
        end
    end

    task automatic b_step(input logic [2:0] v, input logic [2:0] exp_rdy, input int exp_sel);
        b_in_valid = v;
        @(negedge clk);
        chk("n3_in_ready", b_in_ready, exp_rdy);
        @(posedge clk);
        #1;
        chk("n3_out_sel", b_out_sel, exp_sel);
        chk("n3_out_data", b_out_data, b_in_data[exp_sel]);
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data[0] = 4'd1; in_data[1] = 4'd3; in_data[2] = 4'd6; in_data[3] = 4'd9;
        b_rst_n = 1'b0; b_mode = 1'b1; b_out_ready = 1'b1; b_in_valid = '0;
        b_in_data[0] = 4'hA; b_in_data[1] = 4'hB; b_in_data[2] = 4'hC;
        @(posedge clk);
        #1;

        // Reset held two cycles with every channel requesting.
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        rst_n = 1'b1;

        // Fixed priority: channel 0 always wins, then channel 1 once it drops.
        repeat (4) step();
        in_valid = 4'b1110;
        repeat (2) step();

        // Round-robin from ptr=0: 0,1,2,3,0,1.
        mode     = 1'b1;
        in_valid = 4'b1111;
        repeat (6) step();

        // Grant ch2 (ptr->3), stall three cycles, then release with only ch3 valid.
        step();
        out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_out_sel", out_sel, 2);
            chk("bp_out_data", out_data, 6);
        end
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        step();
        in_valid = 4'b0000;
        step();
        step();

        // Randomized traffic with producers holding data while stalled.
        for (int c = 0; c < 600; c++) begin
            if (($urandom % 16) == 0) mode = $urandom_range(0, 1);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && i != lastg)) begin
                    in_valid[i] = ($urandom % 3) != 0;
                    in_data[i]  = W'($urandom);
                end
            end
            step();
        end

        // Reset mid-operation: held word discarded, ptr back to 0.
        mode      = 1'b1;
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        step();
        in_valid  = 4'b1111;
        rst_n     = 1'b0;
        step();
        chk("mid_rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        in_valid = 4'b0000;
        step();
        step();
        chk("drain_empty", q.size(), 0);

        // N=3 wrap: ch2 -> ptr 0, then ch1 -> ptr 2, then ch2 -> ptr 0, then ch0.
        b_rst_n = 1'b1;
        b_step(3'b100, 3'b100, 2);
        b_step(3'b110, 3'b010, 1);
        b_step(3'b110, 3'b100, 2);
        b_step(3'b111, 3'b001, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_arb_rr.md
# mux_arb_rr

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output, and built-in arbitration. This is the next generation of the team's combinational 2:1 selector. Instead of an external select, the block picks among concurrently valid channels using fixed-priority or round-robin arbitration, registers the winner, and holds it under output backpressure. It sits between multiple producers and a single shared consumer.

## Interface
Parameters:
- WIDTH, default 4: data width per channel, ≥1.
- N, default 4: number of input channels, ≥2; non-power-of-2 values are legal.
- IDXW, default $clog2(N): channel index width; localparam, derived, not overridable.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- mode  in  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- in_data  in  N×WIDTH  packed array; channel i at in_data[i].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept; at most one bit high per cycle.
- out_data  out  WIDTH  registered selected word.
- out_sel  out  IDXW  index of the channel that out_data came from.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  consumer accept.

## Operation
- The output register is either EMPTY (out_valid=0) or FULL (out_valid=1). These are the two FSM states.
- Slot free: `load_ok = !out_valid || out_ready`.
- Grant: when load_ok and |in_valid, the arbiter picks exactly one channel g.
  - in_ready[g]=1 combinationally; all other in_ready bits are 0.
  - At the clock edge: out_data←in_data[g], out_sel←g, out_valid←1.
- When load_ok is low, all in_ready are 0 and the register holds.
- When out_valid && out_ready and no in_valid bit is set, the next state is EMPTY. out_data and out_sel keep their last values.
- Transitions:
  - EMPTY→FULL on grant.
  - FULL→FULL on (out_ready && grant) or !out_ready.
  - FULL→EMPTY on out_ready && no request.
- Fixed mode: g = lowest index with in_valid set. The rr pointer is not updated.
- Round-robin mode:
  - ptr (IDXW bits) marks the highest-priority channel.
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - After a grant, ptr←(g==N-1) ? 0 : g+1. Wrap is explicit, so ptr never reaches values ≥N for non-power-of-2 N.
- Mode changes take effect at the next grant. ptr keeps its value across mode switches.
- The block never drops or duplicates a word.
  - A word transfers on the input side iff in_valid[i]&&in_ready[i].
  - A word transfers on the output side iff out_valid&&out_ready.
- Producers hold data stable while valid && !ready. The block does not check this.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready is forced to 0 while rst_n=0.
  - A reset mid-operation discards the held word.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle while out_ready=1 and at least one channel requests.
- in_ready depends combinationally on in_valid, out_valid, out_ready, mode and ptr. There is no combinational path from in_data.
- While out_valid && !out_ready: out_data and out_sel are stable, and ptr is unchanged.
- Simultaneous pop and grant in FULL: the new word replaces the old one in the same edge, with no bubble.

## Structure
- Package mux_pkg holds:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mode_t.
  - typedef enum logic {ST_EMPTY, ST_FULL} state_t.
- Sub-module rr_grant (combinational, parametrised N):
  - Inputs: req[N], ptr, mode.
  - Outputs: grant one-hot [N], idx [IDXW], any.
- The top level holds the output register, the FSM and the ptr update.

## Test plan
All scenarios use N=4, WIDTH=4 unless stated.
- Reset: rst_n=0 for 2 cycles with in_valid=1111 → out_valid=0, out_data=0, out_sel=0, in_ready=0000 throughout.
- Fixed priority: mode=0, in_valid=1111, in_data={9,6,3,1}, out_ready=1 → every cycle in_ready=0001, out_sel=0, out_data=1. Then drop in_valid[0] → next word out_sel=1, out_data=3.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 6 cycles → out_sel sequence 0,1,2,3,0,1, one word per cycle, no bubbles.
- Backpressure: FULL with out_sel=2, out_ready=0 for 3 cycles → out_data and out_sel stable, in_ready=0000, ptr stays 3. Raise out_ready with in_valid=1000 → next cycle out_sel=3, out_data=in_data[3].
- Wrap and skip, N=3: mode=1, grant ch2 so ptr wraps to 0, then in_valid=110 → grant ch1, then ptr=2 → grant ch2. ptr never reaches 3.
- Reset mid-operation: out_valid=1, ptr=2, rst_n=0 for one edge → out_valid=0, ptr=0. Next, with in_valid=1111, mode=1 → first grant out_sel=0.
